// File: rtl/dut_div_pkg.sv
// Shared widths, limits and FSM state type for the sequential signed divider.
package dut_div_pkg;

   localparam int unsigned DIVIDEND_W = 32;
   localparam int unsigned DIVISOR_W  = 17;
   localparam int unsigned QUOT_W     = 15;
   localparam int unsigned REM_W      = DIVISOR_W + 1;
   localparam int unsigned ITER       = DIVIDEND_W;
   localparam int unsigned CNT_W      = $clog2(ITER);

   localparam int QMAX = 16383;
   localparam int QMIN = -16384;

   // Saturation limits, as 15-bit codes and as unsigned quotient-magnitude thresholds
   localparam logic [QUOT_W-1:0]     QMAX_Q     = QUOT_W'(QMAX);
   localparam logic [QUOT_W-1:0]     QMIN_Q     = QUOT_W'(QMIN);
   localparam logic [DIVIDEND_W-1:0] UQ_POS_LIM = DIVIDEND_W'(QMAX);
   localparam logic [DIVIDEND_W-1:0] UQ_NEG_LIM = DIVIDEND_W'(-QMIN);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIN,
      DONE
   } state_e;

endpackage

// File: rtl/dut_sdiv_32s_17ns_15s_seq_if.sv
// Operand/result handshake bundle for the signed divider.
interface dut_sdiv_32s_17ns_15s_seq_if;
   import dut_div_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic signed [DIVIDEND_W-1:0] din0;
   logic        [DIVISOR_W-1:0]  din1;
   logic                         out_valid;
   logic                         out_ready;
   logic        [QUOT_W-1:0]     dout_quot;
   logic        [REM_W-1:0]      dout_rem;
   logic                         dout_ovf;
   logic                         dout_dbz;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, dout_quot, dout_rem, dout_ovf, dout_dbz
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, dout_quot, dout_rem, dout_ovf, dout_dbz
   );

endinterface

// File: rtl/dut_udiv_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module dut_udiv_step
   import dut_div_pkg::*;
(
   input  logic [REM_W-1:0]     i_rem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_div,
   output logic [REM_W-1:0]     o_rem,
   output logic                 o_qbit
);

   logic [REM_W:0] w_shift;
   logic [REM_W:0] w_div_ext;

   // Shift in the next dividend bit, subtract the divisor when it fits
   always_comb begin
      w_shift   = {i_rem, i_bit};
      w_div_ext = {2'b00, i_div};
      o_qbit    = (w_shift >= w_div_ext);
      o_rem     = o_qbit ? REM_W'(w_shift - w_div_ext) : w_shift[REM_W-1:0];
   end

endmodule

// File: rtl/dut_sdiv_32s_17ns_15s_seq.sv
// Sequential signed divider: 32b signed / 17b unsigned -> saturated 15b quotient,
// 18b remainder. One quotient bit per clock, valid/ready on both sides.
module dut_sdiv_32s_17ns_15s_seq
   import dut_div_pkg::*;
(
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   dut_sdiv_32s_17ns_15s_seq_if.slave bus
);

   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_sign;
   logic                  r_dbz_op;
   // Holds |dividend| on entry; quotient bits shift in from the LSB as it empties
   logic [DIVIDEND_W-1:0] r_mag;
   logic [DIVISOR_W-1:0]  r_div;
   logic [REM_W-1:0]      r_rem;

   logic [QUOT_W-1:0]     r_quot;
   logic [REM_W-1:0]      r_dout_rem;
   logic                  r_ovf;
   logic                  r_dbz;

   logic                  w_in_ready;
   logic                  w_out_valid;
   logic [REM_W-1:0]      w_rem_nxt;
   logic                  w_qbit;
   logic [QUOT_W-1:0]     w_q_mag;
   logic [QUOT_W-1:0]     w_fin_quot;
   logic [REM_W-1:0]      w_fin_rem;
   logic                  w_fin_ovf;

   dut_udiv_step u_step (
      .i_rem  (r_rem),
      .i_bit  (r_mag[DIVIDEND_W-1]),
      .i_div  (r_div),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = BUSY;
         end
         BUSY: begin
            if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = FIN;
         end
         FIN: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sign restoration and saturation of the unsigned quotient/remainder
   always_comb begin
      w_q_mag    = r_mag[QUOT_W-1:0];
      w_fin_quot = r_sign ? -w_q_mag : w_q_mag;
      w_fin_rem  = r_sign ? -r_rem : r_rem;
      w_fin_ovf  = 1'b0;
      if (r_dbz_op) begin
         w_fin_quot = r_sign ? QMIN_Q : QMAX_Q;
         w_fin_rem  = '0;
      end else if (!r_sign && (r_mag > UQ_POS_LIM)) begin
         w_fin_quot = QMAX_Q;
         w_fin_ovf  = 1'b1;
      end else if (r_sign && (r_mag > UQ_NEG_LIM)) begin
         w_fin_quot = QMIN_Q;
         w_fin_ovf  = 1'b1;
      end
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_dbz_op   <= 1'b0;
         r_mag      <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_dout_rem <= '0;
         r_ovf      <= 1'b0;
         r_dbz      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_sign   <= bus.din0[DIVIDEND_W-1];
                  // -2^31 negates to 0x8000_0000, which is the correct unsigned magnitude
                  r_mag    <= bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;
                  r_div    <= bus.din1;
                  r_dbz_op <= (bus.din1 == '0);
                  r_cnt    <= '0;
                  r_rem    <= '0;
               end
            end
            BUSY: begin
               r_rem <= w_rem_nxt;
               r_mag <= {r_mag[DIVIDEND_W-2:0], w_qbit};
               r_cnt <= r_cnt + 1'b1;
            end
            FIN: begin
               r_quot     <= w_fin_quot;
               r_dout_rem <= w_fin_rem;
               r_ovf      <= w_fin_ovf;
               r_dbz      <= r_dbz_op;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.dout_quot = r_quot;
   assign bus.dout_rem  = r_dout_rem;
   assign bus.dout_ovf  = r_ovf;
   assign bus.dout_dbz  = r_dbz;

endmodule

// File: tb/tb_dut_sdiv_32s_17ns_15s_seq.sv
// Self-checking bench for the sequential signed divider.
module tb_dut_sdiv_32s_17ns_15s_seq;

   logic ap_clk;
   logic ap_rst_n;
   int   n_cmp;
   int   n_fail;

   dut_sdiv_32s_17ns_15s_seq_if bus ();

   dut_sdiv_32s_17ns_15s_seq dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   // Reference: plain integer division truncating toward zero, then saturation
   function automatic void model(input logic [31:0] d0, input logic [16:0] d1,
                                 output logic [14:0] q, output logic [17:0] r,
                                 output logic ovf, output logic dbz);
      longint a, b, qq, rr;
      a = longint'($signed(d0));
      b = longint'(d1);
      if (b == 0) begin
         dbz = 1'b1;
         ovf = 1'b0;
         r   = '0;
         q   = (a < 0) ? 15'h4000 : 15'h3fff;
      end else begin
         qq  = a / b;
         rr  = a % b;
         dbz = 1'b0;
         r   = rr[17:0];
         if (qq > 16383) begin
            q = 15'h3fff; ovf = 1'b1;
         end else if (qq < -16384) begin
            q = 15'h4000; ovf = 1'b1;
         end else begin
            q = qq[14:0]; ovf = 1'b0;
         end
      end
   endfunction

   // Drive one operation from a point #1 after a rising edge; lat counts edges after accept
   task automatic do_op(input logic [31:0] d0, input logic [16:0] d1, input bit noisy,
                        input bit ack, output logic [14:0] q, output logic [17:0] r,
                        output logic ovf, output logic dbz, output int lat);
      bus.din0     = d0;
      bus.din1     = d1;
      bus.in_valid = 1'b1;
      @(posedge ap_clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         if (noisy) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.din0      = $urandom;
            bus.din1      = 17'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
         end
         @(posedge ap_clk); #1;
         lat++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      q   = bus.dout_quot;
      r   = bus.dout_rem;
      ovf = bus.dout_ovf;
      dbz = bus.dout_dbz;
      if (ack) begin
         bus.out_ready = 1'b1;
         @(posedge ap_clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      ap_rst_n      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.din0      = '0;
      bus.din1      = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dout_quot !== 15'd0 ||
          bus.dout_rem !== 18'd0 || bus.dout_ovf !== 1'b0 || bus.dout_dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: rdy=%b vld=%b q=%h r=%h ovf=%b dbz=%b, want 1 0 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.dout_quot, bus.dout_rem, bus.dout_ovf,
                  bus.dout_dbz);
      end
      ap_rst_n = 1'b1;
      // out_ready in IDLE must not produce anything
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(posedge ap_clk); #1;
         n_cmp++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_out_ready: vld=%b rdy=%b, want 0 1", bus.out_valid,
                     bus.in_ready);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_directed();
      int d0 [11] = '{1000, -1000, -16384, -16385, 2147483647, int'(32'h8000_0000),
                      int'(32'h8000_0000), 0, 500, -500, 84};
      int d1 [11] = '{7, 7, 1, 1, 1, 131071, 1, 12345, 0, 0, 4};
      // -2^31 = -16384*131071 - 16384, so that remainder is -16384
      int eq [11] = '{142, -142, -16384, -16384, 16383, -16384, -16384, 0, 16383, -16384, 21};
      int er [11] = '{6, -6, 0, 0, 0, -16384, 0, 0, 0, 0, 0};
      bit eo [11] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
      bit ez [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
      logic [14:0] q;
      logic [17:0] r;
      logic        ovf, dbz;
      int          lat;
      for (int i = 0; i < 11; i++) begin
         do_op(32'(d0[i]), 17'(d1[i]), 1'b0, 1'b1, q, r, ovf, dbz, lat);
         n_cmp++;
         if ($signed(q) !== eq[i] || $signed(r) !== er[i] || ovf !== eo[i] || dbz !== ez[i])
         begin
            n_fail++;
            $display("FAIL directed_%0d: %0d/%0d got q=%0d r=%0d ovf=%b dbz=%b, want %0d %0d %b %b",
                     i, d0[i], d1[i], $signed(q), $signed(r), ovf, dbz, eq[i], er[i], eo[i],
                     ez[i]);
         end
         n_cmp++;
         if (lat !== 33) begin
            n_fail++;
            $display("FAIL directed_latency_%0d: got %0d, want 33", i, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [14:0] q, mq;
      logic [17:0] r, mr;
      logic        ovf, dbz, mo, mz;
      int          lat;
      model(32'd777777, 17'd333, mq, mr, mo, mz);
      do_op(32'd777777, 17'd333, 1'b0, 1'b0, q, r, ovf, dbz, lat);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (bus.dout_quot !== mq || bus.dout_rem !== mr || bus.dout_ovf !== mo ||
             bus.dout_dbz !== mz || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold_%0d: q=%h r=%h o=%b z=%b vld=%b rdy=%b, want %h %h %b %b 1 0",
                     c, bus.dout_quot, bus.dout_rem, bus.dout_ovf, bus.dout_dbz,
                     bus.out_valid, bus.in_ready, mq, mr, mo, mz);
         end
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.din0     = $urandom;
         bus.din1     = 17'($urandom);
         @(posedge ap_clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge ap_clk); #1;
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_release: vld=%b rdy=%b, want 0 1", bus.out_valid,
                  bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] q;
      logic [17:0] r;
      logic        ovf, dbz;
      int          lat, seen;
      do_op(32'd1000, 17'd7, 1'b0, 1'b1, q, r, ovf, dbz, lat);
      bus.din0     = 32'd123456;
      bus.din1     = 17'd5;
      bus.in_valid = 1'b1;
      @(posedge ap_clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dout_quot !== 15'd0 ||
          bus.dout_rem !== 18'd0 || bus.dout_ovf !== 1'b0 || bus.dout_dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_busy: rdy=%b vld=%b q=%h r=%h ovf=%b dbz=%b, want 1 0 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.dout_quot, bus.dout_rem, bus.dout_ovf,
                  bus.dout_dbz);
      end
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge ap_clk); #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_stale_valid: out_valid high %0d cycles, want 0", seen);
      end
      do_op(32'd84, 17'd4, 1'b0, 1'b1, q, r, ovf, dbz, lat);
      n_cmp++;
      if (q !== 15'd21 || r !== 18'd0 || ovf !== 1'b0 || dbz !== 1'b0 || lat !== 33) begin
         n_fail++;
         $display("FAIL reset_recover: q=%0d r=%0d ovf=%b dbz=%b lat=%0d, want 21 0 0 0 33",
                  q, r, ovf, dbz, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] d0;
      logic [16:0] d1;
      logic [14:0] q, mq;
      logic [17:0] r, mr;
      logic        ovf, dbz, mo, mz;
      int          lat;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: begin d0 = $urandom; d1 = 17'($urandom); end
            1: begin d0 = 32'($urandom_range(0, 2097151)) - 32'd1048576; d1 = 17'($urandom); end
            2: begin d0 = 32'($urandom_range(0, 8000000)) - 32'd4000000;
                     d1 = 17'($urandom_range(1, 300)); end
            default: begin d0 = $urandom; d1 = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'd1; end
         endcase
         model(d0, d1, mq, mr, mo, mz);
         do_op(d0, d1, 1'(i % 2), 1'b1, q, r, ovf, dbz, lat);
         n_cmp++;
         if (q !== mq || r !== mr || ovf !== mo || dbz !== mz || lat !== 33) begin
            n_fail++;
            $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d o=%b z=%b lat=%0d, want %0d %0d %b %b 33",
                     i, $signed(d0), d1, $signed(q), $signed(r), ovf, dbz, lat, $signed(mq),
                     $signed(mr), mo, mz);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
